// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder: active-low glyph
// patterns (bit6=G .. bit0=A), special code values and the frame FSM states.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // Frame FSM: COLLECT while the working mask fills, PRESENT while a frame
  // is offered on the output side.
  typedef logic [0:0] state_t;
  localparam state_t COLLECT = 1'b0;
  localparam state_t PRESENT = 1'b1;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational glyph decoder: active-low 7-segment pattern to a 4-bit code.
// Blank yields CODE_BLANK without error; any unknown pattern yields CODE_ERR
// with err set.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic [3:0] code
);

  // Look up the glyph; unrecognised patterns fall through to the error code.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    err  = 1'b0;
    code = CODE_ERR;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Scan decoder for a multiplexed, active-low seven-segment bus. Samples the
// anode/segment pins, captures each digit once its pattern has been stable
// for STABLE_CYCLES cycles, and hands out one complete frame per valid/ready
// transfer. A frame completing while the previous one is still unaccepted is
// dropped and flagged on the sticky overflow output.
// Optional macro SSD_DP_EN adds a decimal-point input (dp) and per-digit
// decimal-point output (dp_out) carried alongside the frame.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
`ifdef SSD_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_ONE  = CW'(1);
  localparam logic [CW-1:0] RUN_ARM  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RUN_FULL = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE_D = NUM_DIGITS'(1);

`ifdef SSD_DP_EN
  localparam int SW = NUM_DIGITS + 8;
`else
  localparam int SW = NUM_DIGITS + 7;
`endif

  logic [NUM_DIGITS-1:0]   s_an;
  logic [6:0]              s_seg;
  logic [SW-1:0]           cur_smp;
  logic [SW-1:0]           prev_smp;
  logic [CW-1:0]           run_cnt;

  logic [NUM_DIGITS-1:0]   low;
  logic                    one_low;
  logic                    run_hit;
  logic [NUM_DIGITS-1:0]   cap_bits;

  logic                    dec_err;
  logic [3:0]              dec_code;

  logic [4*NUM_DIGITS-1:0] work_code;
  logic [NUM_DIGITS-1:0]   work_err;
  logic [NUM_DIGITS-1:0]   mask;
  logic                    mask_full;
  state_t                  state;
  logic                    load;

`ifdef SSD_DP_EN
  logic                    s_dp;
  logic [NUM_DIGITS-1:0]   work_dp;
  assign cur_smp = {s_an, s_seg, s_dp};
`else
  assign cur_smp = {s_an, s_seg};
`endif

  // Register the pins once and track how long the sampled value has held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_an     <= '1;
      s_seg    <= '1;
      prev_smp <= '1;
      run_cnt  <= '0;
`ifdef SSD_DP_EN
      s_dp     <= 1'b1;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      s_an     <= an;
      s_seg    <= seg;
      prev_smp <= cur_smp;
`ifdef SSD_DP_EN
      s_dp     <= dp;
`endif
      if (cur_smp != prev_smp) begin
        run_cnt <= RUN_ONE;
      end else if (run_cnt != RUN_FULL) begin
        run_cnt <= run_cnt + RUN_ONE;
      end
    end
  end

  ssd_seg_decode u_dec (
    .seg  (s_seg),
    .err  (dec_err),
    .code (dec_code)
  );

  // Capture fires once per stable run, and only with exactly one anode low.
  assign low       = ~s_an;
  assign one_low   = (low != '0) && ((low & (low - ONE_D)) == '0);
  assign run_hit   = (cur_smp == prev_smp) && (run_cnt == RUN_ARM);
  assign cap_bits  = (run_hit && one_low) ? low : '0;
  assign mask_full = &mask;

  // A completed frame is handed over unless the previous one is still held.
  assign load = mask_full && ((state == COLLECT) || out_ready);

  // Working slots: latest capture for each digit position wins.
  always_ff @(posedge clk) begin
    // NOTE: the slot storage has no reset; the mask decides which slots are
    // meaningful, and a frame is only presented once every slot was written.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_bits[i]) begin
        work_code[4*i +: 4] <= dec_code;
        work_err[i]         <= dec_err;
`ifdef SSD_DP_EN
        work_dp[i]          <= ~s_dp;
`endif
      end
    end
  end

  // Frame FSM, capture mask and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      mask     <= '0;
      overflow <= 1'b0;
    end else begin
      mask <= mask_full ? cap_bits : (mask | cap_bits);
      case (state)
        COLLECT: if (mask_full) state <= PRESENT;
        PRESENT: begin
          if (out_ready) begin
            if (!mask_full) state <= COLLECT;
          end else if (mask_full) begin
            overflow <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Output registers: frozen except when a completed frame is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits    <= '0;
      digit_err <= '0;
`ifdef SSD_DP_EN
      dp_out    <= '0;
`endif
    end else if (load) begin
      digits    <= work_code;
      digit_err <= work_err;
`ifdef SSD_DP_EN
      dp_out    <= work_dp;
`endif
    end
  end

  assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scan sequences, a frame-level model
// compared against the outputs every cycle, and literal frame expectations.
`timescale 1ns/1ps
module tb_ssd_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ND-1:0]   an = '1;
  logic [6:0]      seg = '1;
  logic            out_ready = 1'b1;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_err;
  logic            out_valid;
  logic            overflow;
`ifdef SSD_DP_EN
  logic            dp = 1'b1;
  logic [ND-1:0]   dp_out;
`endif

  ssd_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .an        (an),
    .seg       (seg),
`ifdef SSD_DP_EN
    .dp        (dp),
    .dp_out    (dp_out),
`endif
    .digits    (digits),
    .digit_err (digit_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active-low glyphs for digits 0..9.
  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [4:0] model_decode(input logic [6:0] p);
    if (p == 7'h7F) return {1'b0, 4'hF};
    for (int d = 0; d < 10; d++) begin
      if (glyph[d] == p) return {1'b0, 4'(d)};
    end
    return {1'b1, 4'hE};
  endfunction

  // ---------------- behavioural model ----------------
  // A pin value applied for SC consecutive clock edges is captured on the
  // following edge. A full set of slots is presented one edge later.
  logic [ND+6:0]   m_last;
  int              m_run;
  logic [3:0]      m_code [ND];
  logic [ND-1:0]   m_serr;
  logic [ND-1:0]   m_have;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_err;
  logic            m_valid;
  logic            m_ovf;
  int              m_nlow;
  int              m_idx;
  logic [4:0]      m_dec;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_last   = '1;
      m_run    = SC + 1;
      m_have   = '0;
      m_digits = '0;
      m_err    = '0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      // frame hand-off uses the slots as they stood before this edge
      if (m_have == '1) begin
        if (!m_valid || out_ready) begin
          for (int i = 0; i < ND; i++) m_digits[4*i +: 4] = m_code[i];
          m_err   = m_serr;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        m_have = '0;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      // capture the value that has just completed a stable run
      if (m_run == SC) begin
        m_nlow = 0;
        m_idx  = 0;
        for (int i = 0; i < ND; i++) begin
          if (!m_last[7+i]) begin
            m_nlow++;
            m_idx = i;
          end
        end
        if (m_nlow == 1) begin
          m_dec          = model_decode(m_last[6:0]);
          m_code[m_idx]  = m_dec[3:0];
          m_serr[m_idx]  = m_dec[4];
          m_have[m_idx]  = 1'b1;
        end
      end
      // extend or restart the run with the value applied at this edge
      if ({an, seg} == m_last) begin
        if (m_run <= SC) m_run++;
      end else begin
        m_last = {an, seg};
        m_run  = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("digits",    32'(digits),    32'(m_digits));
    check("digit_err", 32'(digit_err), 32'(m_err));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overflow",  32'(overflow),  32'(m_ovf));
  end

  // Frame monitor for the literal expectations.
  int              valid_cycles = 0;
  logic [4*ND-1:0] last_digits = '0;
  logic [ND-1:0]   last_err = '0;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      valid_cycles++;
      last_digits = digits;
      last_err    = digit_err;
    end
  end

  task automatic show(input int d, input logic [6:0] p, input int n);
    an  = ~(ND'(1) << d);
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an  = '1;
    seg = '1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int v0;

  initial begin
    // reset with random pins
    rst_n = 1'b0;
    repeat (2) begin
      an  = ND'($urandom_range(0, (1 << ND) - 1));
      seg = 7'($urandom_range(0, 127));
      @(negedge clk);
    end
    check("rst_digits",    32'(digits),    32'h0);
    check("rst_digit_err", 32'(digit_err), 32'h0);
    check("rst_valid",     32'(out_valid), 32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);
    rst_n = 1'b1;
    idle(3);

    // clean frame 3,0,7,9
    v0 = valid_cycles;
    show(0, glyph[3], 6);
    show(1, glyph[0], 6);
    show(2, glyph[7], 6);
    show(3, glyph[9], 6);
    idle(4);
    check("clean_pulse",  32'(valid_cycles - v0), 32'd1);
    check("clean_digits", 32'(last_digits), 32'h9703);
    check("clean_err",    32'(last_err),    32'h0);
    check("clean_idle",   32'(out_valid),   32'h0);

    // glitch, multi-anode, illegal and blank glyphs
    v0 = valid_cycles;
    show(0, glyph[5], 3);
    show(0, glyph[8], 6);
    an  = 4'b1100;
    seg = glyph[1];
    repeat (10) @(negedge clk);
    show(1, 7'b1010101, 6);
    show(2, 7'b1111111, 6);
    check("no_early_frame", 32'(valid_cycles - v0), 32'd0);
    show(3, glyph[4], 6);
    idle(4);
    check("glitch_pulse",  32'(valid_cycles - v0), 32'd1);
    check("glitch_digits", 32'(last_digits), 32'h4FE8);
    check("glitch_err",    32'(last_err),    32'b0010);

    // backpressure: hold frame A, drop frame B, load C on its completion
    out_ready = 1'b0;
    show(0, glyph[1], 6);
    show(1, glyph[2], 6);
    show(2, glyph[3], 6);
    show(3, glyph[4], 6);
    idle(3);
    check("bp_a_valid",  32'(out_valid), 32'h1);
    check("bp_a_digits", 32'(digits),    32'h4321);
    check("bp_a_ovf",    32'(overflow),  32'h0);
    show(0, glyph[5], 6);
    show(1, glyph[6], 6);
    show(2, glyph[7], 6);
    show(3, glyph[8], 6);
    idle(3);
    check("bp_b_valid",  32'(out_valid), 32'h1);
    check("bp_b_digits", 32'(digits),    32'h4321);
    check("bp_b_ovf",    32'(overflow),  32'h1);
    show(0, glyph[9], 6);
    show(1, glyph[0], 6);
    show(2, glyph[1], 6);
    an  = 4'b0111;
    seg = glyph[2];
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_c_valid",  32'(out_valid), 32'h1);
    check("bp_c_digits", 32'(digits),    32'h2109);
    check("bp_c_ovf",    32'(overflow),  32'h1);
    idle(3);
    check("bp_c_done",   32'(out_valid), 32'h0);

    // reset mid-frame discards partial captures
    show(0, glyph[6], 6);
    show(1, glyph[6], 6);
    rst_n = 1'b0;
    an  = ND'($urandom_range(0, (1 << ND) - 1));
    seg = 7'($urandom_range(0, 127));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ovf",    32'(overflow),  32'h0);
    check("mid_rst_valid",  32'(out_valid), 32'h0);
    check("mid_rst_digits", 32'(digits),    32'h0);
    v0 = valid_cycles;
    show(2, glyph[2], 6);
    show(3, glyph[5], 6);
    idle(3);
    check("mid_rst_partial", 32'(valid_cycles - v0), 32'd0);
    show(0, glyph[1], 6);
    show(1, glyph[8], 6);
    idle(3);
    check("mid_rst_pulse",  32'(valid_cycles - v0), 32'd1);
    check("mid_rst_frame",  32'(last_digits), 32'h5281);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Decoder for the display side of the seven-segment protocol: samples a multiplexed, active-low seven-segment bus (anodes + segments A..G) and recovers the 4-bit digit codes per digit position.
- Sits on the test/loopback path behind the segment encoders and display scanner. Lets the design read back or self-check what is driven to the display.
- Delivers one complete frame (all digits) per valid/ready transfer.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive cycles an anode/segment sample must hold before it is captured (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- an  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
- seg  input  7  segments, active-low, bit6=G..bit0=A.
- digits  output  4*NUM_DIGITS  decoded codes; digit i at [4i+3:4i].
- digit_err  output  NUM_DIGITS  per-digit flag: pattern was not a legal glyph.
- out_valid  output  1  frame available on digits/digit_err.
- out_ready  input  1  consumer accepts frame when out_valid && out_ready.
- overflow  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (rst_n=0 at clk edge): digits=0, digit_err=0, out_valid=0, overflow=0, capture mask=0, run counter=0, input sample regs=all-ones. Reset mid-frame discards partial captures.
- Input stage: an/seg registered once (s_an, s_seg). All decisions use the registered values.
- Run counter: increments while {s_an,s_seg} equals the previous cycle's value, saturating at STABLE_CYCLES. Any change resets it to 1.
- Capture: when the counter first reaches STABLE_CYCLES and s_an has exactly one bit low (index i), the decoded code is written to working slot i and mask bit i is set. One write per stable run. s_an all-ones or more than one low: no capture. Counter still runs.
- Decode map (s_seg -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
  - 1111111 (blank) -> 4'hF, err=0.
  - Any other pattern -> 4'hE, err=1.
- Re-capture of an already-masked slot before frame completion overwrites that slot (latest wins).
- FSM, two states:
  - COLLECT: mask filling.
  - PRESENT: out_valid=1, output regs frozen.
- Frame completion: mask all-ones. Completion cycle N -> working slots copied to digits/digit_err at N+1, out_valid=1 from N+1, mask cleared at N+1. Collection of the next frame continues in PRESENT.
- Handshake:
  - out_valid holds, outputs stable, until out_ready=1.
  - Transfer cycle with no new completion -> COLLECT, out_valid=0 next cycle.
- Completion while PRESENT:
  - With out_ready=1 the same cycle: new frame loads, out_valid stays 1, no overflow.
  - With out_ready=0: new frame dropped, overflow set (sticky until reset), mask cleared.
- Latency: a stable pin value captured STABLE_CYCLES+1 cycles after first applied. Last digit -> out_valid is 1 further cycle.

Optional Feature:
- Macro SSD_DP_EN.
- Defined:
  - Extra input dp (1 bit, active-low decimal point) sampled and run-compared alongside seg.
  - Extra output dp_out (NUM_DIGITS bits, active-high) captured and presented with the frame.
  - dp does not affect decode/err.
- Undefined: no dp ports; behaviour otherwise identical.

Decomposition:
- Package ssd_pkg:
  - Glyph constants SEG_0..SEG_9, SEG_BLANK (7-bit, active-low).
  - CODE_BLANK=4'hF, CODE_ERR=4'hE.
  - FSM state typedef (COLLECT, PRESENT).
- Sub-module ssd_seg_decode: combinational 7-bit pattern -> {err, code[3:0]}. Instantiated once on s_seg.

Test Plan:
- Reset: drive rst_n=0 two cycles with random an/seg -> all outputs 0, out_valid=0.
- Clean frame (NUM_DIGITS=4, STABLE_CYCLES=4): scan an=1110/1101/1011/0111 with glyphs 3,0,7,9, 6 cycles each, out_ready=1 -> out_valid pulses one cycle, digits=16'h9703, digit_err=0.
- Glitch/stability: hold digit 0 with glyph 5 for 3 cycles, then 8 -> only 8 captured. an=1100 held 10 cycles -> no capture.
- Illegal/blank: digit 1 seg=1010101, digit 2 seg=1111111 -> slot1=4'hE with digit_err[1]=1, slot2=4'hF with digit_err[2]=0.
- Backpressure: out_ready=0 across two full frames -> first frame held unchanged, overflow=1 after second completion. Raise out_ready in the completion cycle of a third frame -> third frame loaded, out_valid stays 1.
- Reset mid-frame: capture 2 of 4 digits, pulse rst_n low, complete a new full frame -> out_valid only after all 4 digits re-captured.
